updown_mod_counter: RTL
=======================

# updown_mod_counter

Parametrised successor to the team's basic load/increment counter. Adds an up/down direction, a programmable terminal value, a choice of wrap or saturate at the boundaries, an enable, and terminal-count and sticky overflow flags. It is the standard event/interval counter for timers and sequencers in the Lab1 datapath. An optional prescaler can be compiled in.

## Interface

Parameters:
- `WIDTH`, default 8: counter width in bits.
- `PRESCALE_W`, default 4: prescaler width in bits. Used only when `UDMC_PRESCALE_EN` is defined.

Ports:
- `clk`, in, 1: clock. All state changes on its rising edge.
- `rst`, in, 1: reset. Synchronous and active-low; sampled only at the `posedge clk`.
- `en`, in, 1: count enable.
- `ld`, in, 1: load `v` into the counter.
- `v`, in, `WIDTH`: preload value.
- `up`, in, 1: direction. 1 counts up, 0 counts down.
- `sat`, in, 1: boundary mode. 0 wraps, 1 saturates.
- `max`, in, `WIDTH`: terminal value. The legal count range is 0..`max`.
- `clr_ovf`, in, 1: clears `ovf`.
- `presc`, in, `PRESCALE_W`: prescale divisor minus 1. This port exists only with `UDMC_PRESCALE_EN`.
- `count`, out, `WIDTH`: current count, registered.
- `tc`, out, 1: terminal-count pulse, registered.
- `ovf`, out, 1: sticky boundary flag, registered.

## Operation

- Priority on each edge: reset, then `ld`, then step.
- **Reset** (`rst`=0): `count`=0, `tc`=0, `ovf`=0, prescaler=0.
- **Load** (`ld`=1):
  - `count` <= min(`v`, `max`).
  - Prescaler is cleared.
  - `tc` <= 0; `ovf` is unchanged.
  - `ld` overrides `en`.
- **Step**: occurs when `en`=1, `ld`=0 and the tick is true. Without the prescaler, tick is always 1.
- **Up step**:
  - If `count` < `max`, `count` <= `count`+1.
  - Otherwise it is a boundary event: `count` <= 0 when `sat`=0, or `count` <= `max` when `sat`=1.
  - `count` > `max` can arise if `max` is lowered at run time. It is treated as a boundary event, so saturation clamps to `max`.
- **Down step**:
  - If `count` != 0, `count` <= `count`-1.
  - Otherwise it is a boundary event: `count` <= `max` when `sat`=0, or `count` stays 0 when `sat`=1.
- **`tc`**:
  - Set to 1 for exactly the cycle after an edge that performed a boundary event.
  - 0 after every other edge.
  - A saturating attempt counts as a boundary event, so `tc` pulses every cycle while pinned at a boundary with `en`=1.
- **`ovf`**:
  - Set on any boundary event and held until `clr_ovf`=1.
  - If a boundary event and `clr_ovf` occur on the same edge, the set wins and `ovf` stays 1.
- **`max`=0**: every step is a boundary event. `count` stays 0 and `tc` pulses on every step.
- **Arithmetic**: all arithmetic is modulo 2^`WIDTH`. No internal value is wider than `WIDTH`, except the prescaler at `PRESCALE_W`.
- **`en`=0** with `ld`=0: every register holds, except `tc`, which goes to 0.

## Timing

- Inputs are sampled at the rising edge. Outputs update at that same edge, so latency from input to output is 1 cycle.
- `tc` and `ovf` are registered with `count`. `tc` is high in the same cycle that `count` shows the wrapped or saturated value.
- No combinational path from any input to any output.
- **Reset in mid-operation**: takes effect at the next edge regardless of `ld`, `en` or the prescaler phase. Outputs show the reset values in the following cycle.
- No handshake. `ld` and `en` are level inputs sampled on every edge.

## Configuration

- Macro: `UDMC_PRESCALE_EN`.
- **Defined**:
  - The `presc` port and an internal prescaler of `PRESCALE_W` bits exist.
  - While `en`=1 and `ld`=0, the prescaler increments each cycle.
  - When the prescaler equals `presc`, tick=1 and the prescaler returns to 0 on that edge. The counter therefore steps once every `presc`+1 enabled cycles.
  - `presc`=0 gives a step on every enabled cycle.
  - `en`=0 holds the prescaler. Reset and `ld` clear it.
- **Undefined**: no `presc` port and no prescaler logic. Tick is 1 and the counter steps on every enabled cycle.

## Test plan

- **Reset and up-count with wrap**: hold `rst`=0 for 2 cycles, then release with `en`=1, `up`=1, `sat`=0, `max`=5. Required:
  - `count` is 0 after reset and all flags are 0.
  - `count` runs 1,2,3,4,5,0.
  - `tc`=1 only in the cycle showing 0, and `ovf`=1 from then on.
- **Down-count with saturation**: load `v`=2 with `up`=0, `sat`=1, `max`=9. Required:
  - `count` runs 2,1,0,0,0.
  - `tc`=1 in each cycle after the attempts at 0.
  - `count` never shows 255.
- **Load clamp and priority**: `ld`=1 with `en`=1, `v`=200, `max`=100. Required:
  - `count`=100 and `tc`=0.
  - Next up step with `sat`=0 gives `count`=0 and `tc`=1.
- **Flag interplay**: set `ovf`, then hold `clr_ovf`=1 during a wrap event. Required:
  - `ovf` stays 1.
  - `clr_ovf` on the next non-boundary edge gives `ovf`=0.
- **Runtime `max` change**: at `count`=50, change `max` from 200 to 10 with `up`=1, `sat`=1. Required: next step gives `count`=10 and `tc`=1.
- **Prescaler** (only with `UDMC_PRESCALE_EN`): `presc`=3 and `en`=1 for 12 cycles from 0. Required: `count` reaches 3, stepping every 4th cycle. Then drop `rst` mid-run. Required: the next cycle shows `count`=0 and the prescaler restarts from 0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter: wrap or saturate at 0..max, load with clamp, tc pulse, sticky ovf.
// Latency: 1 cycle from sampled inputs to registered count/tc/ovf; no input-to-output comb path.
// Backpressure: none; ld and en are level inputs sampled every edge. UDMC_PRESCALE_EN adds presc port and prescaler.
module updown_mod_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld,
  input  logic [WIDTH-1:0]      v,
  input  logic                  up,
  input  logic                  sat,
  input  logic [WIDTH-1:0]      max,
  input  logic                  clr_ovf,
`ifdef UDMC_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf
);

  logic             tick;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] count_load;

`ifdef UDMC_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_q;

  // Tick fires on the cycle the prescaler phase reaches the programmed divisor.
  always_comb begin
    tick = (pre_q == presc);
  end

  // Prescaler phase: cleared by reset/load, advances only while enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (ld) begin
      pre_q <= '0;
    end else if (en) begin
      if (pre_q == presc) pre_q <= '0;
      else                pre_q <= pre_q + PRESCALE_W'(1);
    end
  end
`else
  logic [PRESCALE_W-1:0] unused_prescale_w;
  assign unused_prescale_w = '0;

  // Without a prescaler every enabled cycle is a step.
  always_comb begin
    tick = 1'b1;
  end
`endif

  // Boundary detection and next-count selection for a step and for a load.
  // count > max (max lowered at run time) counts as an up boundary so saturation clamps.
  always_comb begin
    step       = en & ~ld & tick;
    boundary   = 1'b0;
    count_step = count;
    count_load = (v > max) ? max : v;
    if (up) begin
      if (count < max) begin
        count_step = count + WIDTH'(1);
      end else begin
        boundary   = 1'b1;
        count_step = sat ? max : '0;
      end
    end else begin
      if (count != '0) begin
        count_step = count - WIDTH'(1);
      end else begin
        boundary   = 1'b1;
        count_step = sat ? '0 : max;
      end
    end
  end

  // Count, terminal-count pulse and sticky overflow; boundary set beats clr_ovf.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      tc <= step & boundary;
      if (ld) begin
        count <= count_load;
      end else if (step) begin
        count <= count_step;
      end
      if (step && boundary) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
